// File: rtl/gray_raster_source.sv
// Camera RGB-to-luma front end with raster X/Y tagging.
// Feeds the binarisation threshold stage with an aligned gray/valid/X/Y stream.
module gray_raster_source #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int W_R      = 77,
    parameter int W_G      = 150,
    parameter int W_B      = 29
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    input  logic        iDval,
    input  logic        iFval,
    output logic [7:0]  oGray,
    output logic        oValid,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic        oFrameStart,
    output logic        oFrameDone,
    output logic        oOverrun
);

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] Y_LIM  = 16'(V_ACTIVE);
    localparam logic [17:0] K_R    = 18'(W_R);
    localparam logic [17:0] K_G    = 18'(W_G);
    localparam logic [17:0] K_B    = 18'(W_B);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_HIGH,
        ACTIVE
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic        fvalQ;
    logic        fvalRise;
    logic        fvalFall;
    logic [15:0] xCnt;
    logic [15:0] yCnt;
    logic [15:0] xNext;
    logic [15:0] yNext;
    logic        pixValid;
    logic        pixStart;
    logic        pixDone;
    logic        setOvr;

    logic        s1Valid;
    logic        s1Start;
    logic        s1Done;
    logic [15:0] s1X;
    logic [15:0] s1Y;
    logic [17:0] s1R;
    logic [17:0] s1G;
    logic [17:0] s1B;
    logic [17:0] s1Sum;
    logic [7:0]  s1Gray;

    assign fvalRise = ~fvalQ & iFval;
    assign fvalFall = fvalQ & ~iFval;
    assign pixStart = (xCnt == '0) && (yCnt == '0);
    assign pixDone  = (xCnt == X_LAST) && (yCnt == Y_LAST);

    always_comb begin
        stateNext = state;
        xNext     = xCnt;
        yNext     = yCnt;
        pixValid  = 1'b0;
        setOvr    = 1'b0;
        unique case (state)
            WAIT_LOW: begin
                if (!iFval) begin
                    stateNext = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (fvalRise) begin
                    stateNext = ACTIVE;
                    xNext     = '0;
                    yNext     = '0;
                end
            end
            ACTIVE: begin
                if (iDval) begin
                    // Lines past the frame height are dropped, Y stays pinned
                    if (yCnt >= Y_LIM) begin
                        setOvr = 1'b1;
                    end else begin
                        pixValid = 1'b1;
                        if (xCnt == X_LAST) begin
                            xNext = '0;
                            yNext = yCnt + 16'd1;
                        end else begin
                            xNext = xCnt + 16'd1;
                        end
                    end
                end
                if (fvalFall) begin
                    stateNext = WAIT_HIGH;
                    if (yNext < Y_LIM) begin
                        setOvr = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= WAIT_LOW;
            fvalQ    <= 1'b0;
            xCnt     <= '0;
            yCnt     <= '0;
            oOverrun <= 1'b0;
        end else begin
            state    <= stateNext;
            fvalQ    <= iFval;
            xCnt     <= xNext;
            yCnt     <= yNext;
            oOverrun <= oOverrun | setOvr;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1Valid <= 1'b0;
            s1Start <= 1'b0;
            s1Done  <= 1'b0;
            s1X     <= '0;
            s1Y     <= '0;
            s1R     <= '0;
            s1G     <= '0;
            s1B     <= '0;
        end else begin
            s1Valid <= pixValid;
            s1Start <= pixValid & pixStart;
            s1Done  <= pixValid & pixDone;
            if (pixValid) begin
                s1X <= xCnt;
                s1Y <= yCnt;
                s1R <= K_R * {8'd0, iRed};
                s1G <= K_G * {8'd0, iGreen};
                s1B <= K_B * {8'd0, iBlue};
            end
        end
    end

    // Weights sum to 256, so the top byte of the 18-bit sum is the luma
    assign s1Sum  = s1R + s1G + s1B;
    assign s1Gray = 8'(s1Sum >> 10);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oValid      <= 1'b0;
            oFrameStart <= 1'b0;
            oFrameDone  <= 1'b0;
            oGray       <= '0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
        end else begin
            oValid      <= s1Valid;
            oFrameStart <= s1Start;
            oFrameDone  <= s1Done;
            if (s1Valid) begin
                oGray   <= s1Gray;
                oX_Cont <= s1X;
                oY_Cont <= s1Y;
            end
        end
    end

endmodule

// File: tb/tb_gray_raster_source.sv
// Bench for gray_raster_source: frame-level reference model plus directed vectors.
// Uses a reduced 16x8 raster so full frames stay short.
module tb_gray_raster_source;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int NPIX = H * V;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  r     = '0;
    logic [9:0]  g     = '0;
    logic [9:0]  b     = '0;
    logic        dval  = 1'b0;
    logic        fval  = 1'b0;
    logic [7:0]  oGray;
    logic        oValid;
    logic [15:0] oX;
    logic [15:0] oY;
    logic        oFrameStart;
    logic        oFrameDone;
    logic        oOverrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_raster_source #(
        .H_ACTIVE(H),
        .V_ACTIVE(V)
    ) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iRed       (r),
        .iGreen     (g),
        .iBlue      (b),
        .iDval      (dval),
        .iFval      (fval),
        .oGray      (oGray),
        .oValid     (oValid),
        .oX_Cont    (oX),
        .oY_Cont    (oY),
        .oFrameStart(oFrameStart),
        .oFrameDone (oFrameDone),
        .oOverrun   (oOverrun)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame window, pixel count, 2-deep output delay
    typedef struct {
        bit v;
        bit s;
        bit d;
        int gray;
        int x;
        int y;
    } ent_t;

    ent_t e0 = '{default: 0};
    ent_t e1 = '{default: 0};
    ent_t nw = '{default: 0};
    int   n = 0;
    bit   armed = 0;
    bit   seenLow = 0;
    bit   fPrev = 0;
    bit   mOvr = 0;
    bit   expV = 0;
    bit   expS = 0;
    bit   expD = 0;
    int   expGray = 0;
    int   expX = 0;
    int   expY = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0 = '{default: 0};
            e1 = '{default: 0};
            n = 0; armed = 0; seenLow = 0; fPrev = 0; mOvr = 0;
            expV = 0; expS = 0; expD = 0;
            expGray = 0; expX = 0; expY = 0;
        end else begin
            e1 = e0;
            nw = '{default: 0};
            if (!armed) begin
                if (!seenLow) begin
                    if (!fval) seenLow = 1;
                end else if (!fPrev && fval) begin
                    armed = 1;
                    n = 0;
                end
            end else begin
                if (dval) begin
                    if (n < NPIX) begin
                        nw.v = 1;
                        nw.x = n % H;
                        nw.y = n / H;
                        nw.s = (n == 0);
                        nw.d = (n == NPIX - 1);
                        nw.gray = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) >> 10;
                    end else begin
                        mOvr = 1;
                    end
                    n++;
                end
                if (fPrev && !fval) begin
                    armed = 0;
                    if (n < NPIX) mOvr = 1;
                end
            end
            fPrev = fval;
            e0 = nw;
            expV = e1.v;
            expS = e1.s;
            expD = e1.d;
            if (e1.v) begin
                expGray = e1.gray;
                expX = e1.x;
                expY = e1.y;
            end
        end
    end

    int vCnt = 0;
    int sCnt = 0;
    int dCnt = 0;
    int startX = -1;
    int startY = -1;
    int startGray = -1;
    int doneX = -1;
    int doneY = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", int'(oValid), int'(expV));
            chk("start", int'(oFrameStart), int'(expS));
            chk("done", int'(oFrameDone), int'(expD));
            chk("overrun", int'(oOverrun), int'(mOvr));
            chk("gray", int'(oGray), expGray);
            chk("x", int'(oX), expX);
            chk("y", int'(oY), expY);
            if (oValid) vCnt++;
            if (oFrameStart) begin
                sCnt++;
                startX = int'(oX);
                startY = int'(oY);
                startGray = int'(oGray);
            end
            if (oFrameDone) begin
                dCnt++;
                doneX = int'(oX);
                doneY = int'(oY);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clrCnt();
        vCnt = 0; sCnt = 0; dCnt = 0;
        startX = -1; startY = -1; startGray = -1;
        doneX = -1; doneY = -1;
    endtask

    task automatic frameBegin();
        tick(); fval = 1'b1;
        tick(); tick();
    endtask

    task automatic frameEnd();
        tick(); fval = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic stream(input int cnt, input int mode, input bit lastFall);
        for (int i = 0; i < cnt; i++) begin
            tick();
            dval = 1'b1;
            if (mode == 0) begin
                r = 10'd1023; g = 10'd1023; b = 10'd1023;
            end else begin
                r = 10'((i * 37) % 1024);
                g = 10'((i * 91 + 5) % 1024);
                b = 10'((i * 13 + 100) % 1024);
            end
            if (lastFall && i == cnt - 1) fval = 1'b0;
        end
        tick();
        dval = 1'b0;
    endtask

    task automatic px(input int rv, input int gv, input int bv,
                      input int eg, input string nm);
        tick();
        dval = 1'b1;
        r = 10'(rv); g = 10'(gv); b = 10'(bv);
        tick();
        dval = 1'b0;
        chk({nm, "_early"}, int'(oValid), 0);
        tick();
        chk({nm, "_valid"}, int'(oValid), 1);
        chk({nm, "_gray"}, int'(oGray), eg);
    endtask

    task automatic pulseReset();
        tick(); rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
    endtask

    initial begin
        tick(); tick();
        chk("rst_valid", int'(oValid), 0);
        chk("rst_ovr", int'(oOverrun), 0);
        chk("rst_gray", int'(oGray), 0);
        rst_n = 1'b1;
        tick(); tick();

        // Full white frame
        clrCnt();
        frameBegin();
        stream(NPIX, 0, 0);
        frameEnd();
        chk("t1_vcnt", vCnt, NPIX);
        chk("t1_scnt", sCnt, 1);
        chk("t1_dcnt", dCnt, 1);
        chk("t1_start_x", startX, 0);
        chk("t1_start_y", startY, 0);
        chk("t1_start_gray", startGray, 255);
        chk("t1_done_x", doneX, H - 1);
        chk("t1_done_y", doneY, V - 1);
        chk("t1_ovr", int'(oOverrun), 0);

        // Line wrap with gaps, then single-channel pixels
        clrCnt();
        frameBegin();
        for (int i = 0; i <= H; i++) begin
            px(4 * i, 4 * i, 4 * i, i, "t3_px");
            if (i == H - 1) begin
                chk("t3_last_x", int'(oX), H - 1);
                chk("t3_last_y", int'(oY), 0);
            end
            if (i == H) begin
                chk("t3_wrap_x", int'(oX), 0);
                chk("t3_wrap_y", int'(oY), 1);
            end
            tick();
            chk("t3_gap_valid", int'(oValid), 0);
            chk("t3_gap_x", int'(oX), i % H);
        end
        px(1023, 0, 0, 76, "t2_red");
        px(0, 1023, 0, 149, "t2_green");
        px(0, 0, 1023, 28, "t2_blue");
        chk("t2_blue_x", int'(oX), 3);
        chk("t2_blue_y", int'(oY), 1);
        stream(NPIX - H - 4, 1, 0);
        frameEnd();
        chk("t23_vcnt", vCnt, NPIX);
        chk("t23_dcnt", dCnt, 1);
        chk("t23_ovr", int'(oOverrun), 0);

        // Short frame, then a normal frame ending with a same-cycle fall
        clrCnt();
        frameBegin();
        stream(40, 1, 0);
        frameEnd();
        chk("t4_short_ovr", int'(oOverrun), 1);
        chk("t4_short_vcnt", vCnt, 40);
        chk("t4_short_dcnt", dCnt, 0);
        clrCnt();
        frameBegin();
        stream(NPIX, 1, 1);
        frameEnd();
        chk("t4_next_vcnt", vCnt, NPIX);
        chk("t4_next_scnt", sCnt, 1);
        chk("t4_next_start_x", startX, 0);
        chk("t4_next_start_y", startY, 0);
        chk("t4_next_dcnt", dCnt, 1);
        chk("t4_sticky_ovr", int'(oOverrun), 1);

        // Over-long frame
        pulseReset();
        chk("t5_rst_ovr", int'(oOverrun), 0);
        clrCnt();
        frameBegin();
        stream(NPIX, 1, 0);
        tick(); tick(); tick();
        chk("t5_pre_ovr", int'(oOverrun), 0);
        stream(5, 1, 0);
        tick(); tick(); tick();
        chk("t5_post_ovr", int'(oOverrun), 1);
        frameEnd();
        chk("t5_vcnt", vCnt, NPIX);
        chk("t5_dcnt", dCnt, 1);
        chk("t5_ovr", int'(oOverrun), 1);

        // Reset in the middle of a frame
        pulseReset();
        frameBegin();
        stream(5 + 3 * H, 1, 0);
        tick();
        rst_n = 1'b0;
        tick(); tick();
        chk("t6_rst_valid", int'(oValid), 0);
        chk("t6_rst_ovr", int'(oOverrun), 0);
        rst_n = 1'b1;
        clrCnt();
        stream(20, 1, 0);
        tick(); tick();
        chk("t6_ignored_vcnt", vCnt, 0);
        frameEnd();
        clrCnt();
        frameBegin();
        stream(NPIX, 0, 0);
        frameEnd();
        chk("t6_vcnt", vCnt, NPIX);
        chk("t6_scnt", sCnt, 1);
        chk("t6_start_x", startX, 0);
        chk("t6_start_y", startY, 0);
        chk("t6_start_gray", startGray, 255);
        chk("t6_ovr", int'(oOverrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
